// File: rtl/multicycle_alu_control.sv
// Multicycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback,
// drives ALU op and datapath controls, and watches memory handshakes with a timeout.
module multicycle_alu_control #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic [3:0] ALUOperation,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       ExtZero,
   output logic       PCEn,
   output logic [1:0] PCSource,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic       Fault,
   output logic [1:0] FaultCause,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_EXEC_R   = 4'd3,
      S_RWB      = 4'd4,
      S_EXEC_I   = 4'd5,
      S_IWB      = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_RD   = 4'd8,
      S_MEM_WB   = 4'd9,
      S_MEM_WR   = 4'd10,
      S_BRANCH   = 4'd11,
      S_JUMP     = 4'd12,
      S_JAL      = 4'd13,
      S_JR       = 4'd14,
      S_FAULT    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C, OP_ORI  = 6'h0D, OP_LUI  = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23, OP_SW   = 6'h2B;
   localparam logic [5:0] FN_SLL   = 6'h00, FN_SRL  = 6'h02, FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20, FN_SUB  = 6'h22, FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25, FN_NOR  = 6'h27;

   localparam logic [3:0] ALU_ADD = 4'b0000, ALU_AND = 4'b0001, ALU_NOR = 4'b0011;
   localparam logic [3:0] ALU_OR  = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110;
   localparam logic [3:0] ALU_SUB = 4'b0111, ALU_BEQ = 4'b1000, ALU_BNE = 4'b1001;
   localparam logic [3:0] ALU_LUI = 4'b1010, ALU_LW  = 4'b1011, ALU_SW  = 4'b1100;

   localparam bit         WD_EN    = (WAIT_LIMIT != 0);
   localparam logic [7:0] WD_LAST  = 8'(WAIT_LIMIT - 1);

   state_t     r_state;
   state_t     w_next;
   logic [5:0] r_opcode;
   logic [5:0] r_funct;
   logic [7:0] r_wait_cnt;
   logic       w_wait_state;
   logic       w_timeout;

   function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
      state_t s;
      s = S_FAULT;
      case (op)
         OP_RTYPE: begin
            case (fn)
               FN_ADD, FN_AND, FN_OR, FN_NOR, FN_SUB, FN_SLL, FN_SRL: s = S_EXEC_R;
               FN_JR:   s = S_JR;
               default: s = S_FAULT;
            endcase
         end
         OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: s = S_EXEC_I;
         OP_LW, OP_SW:                     s = S_MEM_ADDR;
         OP_BEQ, OP_BNE:                   s = S_BRANCH;
         OP_J:                             s = S_JUMP;
         OP_JAL:                           s = S_JAL;
         default:                          s = S_FAULT;
      endcase
      return s;
   endfunction

   function automatic logic [3:0] rtype_code(input logic [5:0] fn);
      logic [3:0] c;
      case (fn)
         FN_AND:  c = ALU_AND;
         FN_OR:   c = ALU_OR;
         FN_NOR:  c = ALU_NOR;
         FN_SUB:  c = ALU_SUB;
         FN_SLL:  c = ALU_SLL;
         FN_SRL:  c = ALU_SRL;
         default: c = ALU_ADD;
      endcase
      return c;
   endfunction

   function automatic logic [3:0] itype_code(input logic [5:0] op);
      logic [3:0] c;
      case (op)
         OP_ANDI: c = ALU_AND;
         OP_ORI:  c = ALU_OR;
         OP_LUI:  c = ALU_LUI;
         default: c = ALU_ADD;
      endcase
      return c;
   endfunction

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   assign w_timeout    = WD_EN && w_wait_state && !MemReady && (r_wait_cnt == WD_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     w_next = S_FETCH;
         S_FETCH:    w_next = MemReady ? S_DECODE : (w_timeout ? S_FAULT : S_FETCH);
         S_DECODE:   w_next = decode_target(Opcode, Funct);
         S_EXEC_R:   w_next = S_RWB;
         S_EXEC_I:   w_next = S_IWB;
         S_MEM_ADDR: w_next = (r_opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   w_next = MemReady ? S_MEM_WB : (w_timeout ? S_FAULT : S_MEM_RD);
         S_MEM_WR:   w_next = MemReady ? S_FETCH : (w_timeout ? S_FAULT : S_MEM_WR);
         S_RWB, S_IWB, S_MEM_WB, S_BRANCH, S_JUMP, S_JAL, S_JR: w_next = S_FETCH;
         S_FAULT:    w_next = S_FAULT;
         default:    w_next = S_FAULT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_opcode   <= 6'd0;
         r_funct    <= 6'd0;
         r_wait_cnt <= 8'd0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) begin
            r_opcode <= Opcode;
            r_funct  <= Funct;
         end
         // Outside wait states the counter sits at 0, so every wait starts fresh.
         if (!w_wait_state || MemReady)
            r_wait_cnt <= 8'd0;
         else if (r_wait_cnt != 8'hFF)
            r_wait_cnt <= r_wait_cnt + 8'd1;
      end
   end

   always_comb begin
      ALUOperation = ALU_ADD;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ExtZero      = 1'b0;
      PCEn         = 1'b0;
      PCSource     = 2'b00;
      IorD         = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      RegDst       = 2'b00;
      MemtoReg     = 2'b00;
      Fault        = 1'b0;
      FaultCause   = 2'b00;
      case (r_state)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = MemReady;
            PCEn    = MemReady;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_EXEC_R: begin
            ALUSrcA      = 1'b1;
            ALUOperation = rtype_code(r_funct);
         end
         S_RWB: begin
            RegWrite = 1'b1;
            RegDst   = 2'b01;
         end
         S_EXEC_I: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = 2'b10;
            ExtZero      = (r_opcode == OP_ANDI) || (r_opcode == OP_ORI);
            ALUOperation = itype_code(r_opcode);
         end
         S_IWB: RegWrite = 1'b1;
         S_MEM_ADDR: begin
            ALUSrcA      = 1'b1;
            ALUSrcB      = 2'b10;
            ALUOperation = (r_opcode == OP_SW) ? ALU_SW : ALU_LW;
         end
         S_MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEM_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
         end
         S_MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         // The BNE ALU code raises Zero on inequality, so Zero alone decides "taken".
         S_BRANCH: begin
            ALUSrcA      = 1'b1;
            ALUOperation = (r_opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
            PCSource     = 2'b01;
            PCEn         = Zero;
         end
         S_JUMP: begin
            PCEn     = 1'b1;
            PCSource = 2'b10;
         end
         S_JAL: begin
            PCEn     = 1'b1;
            PCSource = 2'b10;
            RegWrite = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
         end
         S_JR: begin
            PCEn     = 1'b1;
            PCSource = 2'b11;
         end
         // Latched fields are always legal unless decode faulted, so they encode the cause.
         S_FAULT: begin
            Fault      = 1'b1;
            FaultCause = (decode_target(r_opcode, r_funct) == S_FAULT) ? 2'b01 : 2'b10;
         end
         default: ;
      endcase
   end

   assign State = r_state;

endmodule

// File: tb/tb_multicycle_alu_control.sv
// Directed bench for multicycle_alu_control: walks instruction classes, watchdog and reset cases.
module tb_multicycle_alu_control;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] Opcode = 6'd0;
   logic [5:0] Funct = 6'd0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b1;
   logic [3:0] ALUOperation;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic       ExtZero;
   logic       PCEn;
   logic [1:0] PCSource;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] RegDst;
   logic [1:0] MemtoReg;
   logic       Fault;
   logic [1:0] FaultCause;
   logic [3:0] State;

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   multicycle_alu_control #(.WAIT_LIMIT(4)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .MemReady(MemReady), .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .PCEn(PCEn), .PCSource(PCSource),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Fault(Fault),
      .FaultCause(FaultCause), .State(State)
   );

   logic [26:0] w_all;
   assign w_all = {ALUOperation, ALUSrcA, ALUSrcB, ExtZero, PCEn, PCSource, IorD, MemRead,
                   MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Fault, FaultCause, State};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      // Reset held: everything reads zero.
      Funct = 6'h20;
      tick(); tick();
      check("rst_all_zero", w_all, 0);
      reset = 1'b1; settle();
      check("rel_idle", State, 0);

      // add: IDLE -> FETCH -> DECODE -> EXEC_R -> RWB -> FETCH
      tick(); check("add_fetch_st", State, 1);
      check("fetch_ctl", {MemRead, IorD, ALUSrcA, ALUSrcB, IRWrite, PCEn, PCSource},
            {1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 2'b00});
      tick(); check("add_decode", {State, ALUSrcA, ALUSrcB}, {4'd2, 1'b0, 2'b11});
      tick(); check("add_exec", {State, ALUSrcA, ALUSrcB, ALUOperation}, {4'd3, 1'b1, 2'b00, 4'b0000});
      tick(); check("add_rwb", {State, RegWrite, RegDst, MemtoReg}, {4'd4, 1'b1, 2'b01, 2'b00});
      tick(); check("add_back_fetch", State, 1);

      // lw with three MemReady-low cycles in MEM_RD; opcode changes after decode must not matter
      Opcode = 6'h23;
      tick(); check("lw_decode", State, 2);
      tick(); Opcode = 6'h2B; settle();
      check("lw_addr", {State, ALUSrcA, ALUSrcB, ALUOperation}, {4'd7, 1'b1, 2'b10, 4'b1011});
      MemReady = 1'b0;
      tick(); check("lw_rd1", {State, MemRead, IorD}, {4'd8, 1'b1, 1'b1});
      tick(); check("lw_rd2", State, 8);
      tick(); check("lw_rd3", State, 8);
      MemReady = 1'b1; settle();
      check("lw_rd4", {State, MemRead, IorD}, {4'd8, 1'b1, 1'b1});
      tick(); check("lw_wb", {State, RegWrite, RegDst, MemtoReg}, {4'd9, 1'b1, 2'b00, 2'b01});
      tick(); check("lw_back_fetch", State, 1);

      // beq then bne, both Zero polarities
      Opcode = 6'h04;
      tick(); tick();
      Zero = 1'b1; settle();
      check("beq_taken", {State, PCEn, PCSource, ALUOperation}, {4'd11, 1'b1, 2'b01, 4'b1000});
      Zero = 1'b0; settle();
      check("beq_not_taken", PCEn, 0);
      tick(); check("beq_back_fetch", State, 1);
      Opcode = 6'h05;
      tick(); tick();
      Zero = 1'b1; settle();
      check("bne_taken", {State, PCEn, PCSource, ALUOperation}, {4'd11, 1'b1, 2'b01, 4'b1001});
      Zero = 1'b0; settle();
      check("bne_not_taken", PCEn, 0);
      tick();

      // ori: zero-extended immediate, OR code, writeback to rt
      Opcode = 6'h0D;
      tick(); tick();
      check("ori_exec", {State, ALUSrcA, ALUSrcB, ExtZero, ALUOperation},
            {4'd5, 1'b1, 2'b10, 1'b1, 4'b0100});
      tick(); check("ori_wb", {State, RegWrite, RegDst, MemtoReg}, {4'd6, 1'b1, 2'b00, 2'b00});
      tick();

      // jr
      Opcode = 6'h00; Funct = 6'h08;
      tick(); tick();
      check("jr", {State, PCEn, PCSource, RegWrite}, {4'd14, 1'b1, 2'b11, 1'b0});
      tick();

      // jal
      Opcode = 6'h03;
      tick(); tick();
      check("jal", {State, PCEn, PCSource, RegDst, MemtoReg, RegWrite},
            {4'd13, 1'b1, 2'b10, 2'b10, 2'b10, 1'b1});
      tick(); check("jal_back_fetch", State, 1);

      // watchdog in FETCH: fourth consecutive low cycle faults with cause 10
      MemReady = 1'b0;
      tick(); tick(); tick();
      check("wd_fetch_c4", {State, IRWrite, PCEn}, {4'd1, 1'b0, 1'b0});
      tick();
      check("wd_fault", {State, Fault, FaultCause}, {4'd15, 1'b1, 2'b10});
      reset = 1'b0; settle();
      check("wd_reset", {State, Fault, FaultCause}, {4'd0, 1'b0, 2'b00});
      reset = 1'b1; MemReady = 1'b1;
      tick(); check("wd2_fetch", State, 1);
      MemReady = 1'b0;
      tick(); tick(); tick();
      MemReady = 1'b1; Opcode = 6'h3F; settle();
      check("wd2_c4_ready", {State, IRWrite, PCEn}, {4'd1, 1'b1, 1'b1});
      tick(); check("wd2_decode", State, 2);

      // illegal opcode 0x3F: absorbing FAULT with no strobes
      tick();
      check("ill_op_fault", {State, Fault, FaultCause}, {4'd15, 1'b1, 2'b01});
      for (int i = 0; i < 10; i++) begin
         MemReady = i[0];
         Zero = ~i[0];
         settle();
         check("ill_op_hold", {State, Fault, PCEn, MemRead, MemWrite, IRWrite, RegWrite},
               {4'd15, 1'b1, 5'b00000});
         tick();
      end
      reset = 1'b0; settle();
      check("ill_reset", {State, Fault, FaultCause}, {4'd0, 1'b0, 2'b00});
      reset = 1'b1; MemReady = 1'b1; Zero = 1'b0;

      // illegal funct under R-type opcode
      tick(); Opcode = 6'h00; Funct = 6'h3F;
      tick(); tick();
      check("ill_fn_fault", {State, Fault, FaultCause}, {4'd15, 1'b1, 2'b01});
      reset = 1'b0; settle(); reset = 1'b1;

      // sw, then asynchronous reset in the middle of MEM_WR
      tick(); Opcode = 6'h2B;
      tick(); tick();
      check("sw_addr", {State, ALUOperation}, {4'd7, 4'b1100});
      MemReady = 1'b0;
      tick(); check("sw_wr", {State, MemWrite, IorD}, {4'd10, 1'b1, 1'b1});
      #2; reset = 1'b0; #1;
      check("sw_async_rst", {State, MemWrite, IorD}, {4'd0, 1'b0, 1'b0});

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_alu_control.md
Name: multicycle_alu_control

Overview:
- Multicycle control FSM that sits on the issuing side of the ALU.
- Sequences fetch/decode/execute/memory/writeback for the MIPS subset.
- Drives the 4-bit ALUOperation code, datapath muxes and write enables, and consumes the ALU Zero flag to resolve branches.
- Replaces the single-cycle combinational control in the multicycle datapath; memory accesses use a ready handshake with a watchdog.

Parameters:
WAIT_LIMIT, 255, consecutive MemReady-low cycles tolerated in a wait state before fault; range 1..255; 0 disables watchdog.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Opcode  input  6  instruction bits [31:26] from memory data bus, sampled in DECODE
Funct  input  6  instruction bits [5:0], sampled in DECODE
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes current access this cycle
ALUOperation  output  4  ADD 0000, AND 0001, NOR 0011, OR 0100, SLL 0101, SRL 0110, SUB 0111, BEQ 1000, BNE 1001, LUI 1010, LW 1011, SW 1100
ALUSrcA  output  1  0=PC, 1=register A
ALUSrcB  output  2  00=register B, 01=const 4, 10=extended imm, 11=sign-ext imm<<2
ExtZero  output  1  1=zero-extend imm (andi/ori), else sign-extend
PCEn  output  1  PC load enable
PCSource  output  2  00=ALUResult, 01=ALUOut, 10=jump target, 11=register A
IorD  output  1  0=PC address, 1=ALUOut address
MemRead, MemWrite, IRWrite, RegWrite  output  1 each  strobes
RegDst  output  2  00=rt, 01=rd, 10=$31
MemtoReg  output  2  00=ALUOut, 01=MDR, 10=PC
Fault  output  1  FSM halted in FAULT
FaultCause  output  2  00 none, 01 illegal opcode/funct, 10 memory timeout
State  output  4  current state code (debug)

Behaviour:
- Structure: state register, latched Opcode/Funct, 8-bit wait counter are the only flops. Outputs are combinational from state, latched fields, Zero and MemReady.
- Unlisted outputs are 0 in every state; ALUOperation defaults to ADD.
- Reset: reset low immediately forces state IDLE, latches to 0, counter to 0 and FaultCause to 00. All outputs read 0 while low, including mid-access.
- State codes: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, RWB 4, EXEC_I 5, IWB 6, MEM_ADDR 7, MEM_RD 8, MEM_WB 9, MEM_WR 10, BRANCH 11, JUMP 12, JAL 13, JR 14, FAULT 15.
- IDLE: outputs 0; -> FETCH next cycle.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ADD. Stays while MemReady=0. When MemReady=1: IRWrite=1, PCEn=1, PCSource=00, -> DECODE.
- DECODE: latch Opcode/Funct; ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next state by opcode:
  - 0x00 + funct add 0x20/and 0x24/or 0x25/nor 0x27/sub 0x22/sll 0x00/srl 0x02 -> EXEC_R; funct jr 0x08 -> JR.
  - addi 0x08, andi 0x0C, ori 0x0D, lui 0x0F -> EXEC_I.
  - lw 0x23, sw 0x2B -> MEM_ADDR.
  - beq 0x04, bne 0x05 -> BRANCH.
  - j 0x02 -> JUMP; jal 0x03 -> JAL.
  - anything else -> FAULT, cause 01.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, code from funct (sll/srl use shamt, A ignored) -> RWB.
- RWB: RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ExtZero=1 for andi/ori; codes ADD/AND/OR/LUI -> IWB.
- IWB: RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, code LW or SW -> MEM_RD (lw) / MEM_WR (sw).
- MEM_RD: MemRead=1, IorD=1; hold until MemReady -> MEM_WB.
- MEM_WB: RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; hold until MemReady -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, code BEQ/BNE, PCSource=01, PCEn=Zero -> FETCH. The BNE code yields Zero=1 when operands differ, so taken iff Zero=1 for both.
- JUMP: PCEn=1, PCSource=10. JAL: additionally RegWrite=1, RegDst=10, MemtoReg=10. JR: PCEn=1, PCSource=11. All -> FETCH.
- Watchdog: counter clears on entry to FETCH/MEM_RD/MEM_WR and whenever MemReady=1, and increments each MemReady-low cycle. On the WAIT_LIMIT-th consecutive low cycle the transition is FAULT, cause 10, with no strobe committed. MemReady=1 on that same cycle wins (normal transition).
- FAULT: Fault=1, all strobes 0, absorbing until reset.
- Throughput: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3 (MemReady=1 throughout).

Test Plan:
- Release reset, MemReady=1, Opcode 0x00 Funct 0x20 -> State 0,1,2,3,4,1; EXEC_R ALUOperation=0000; RWB RegWrite=1 RegDst=01.
- lw (0x23), MemReady low 3 cycles in MEM_RD -> MEM_ADDR ALUOperation=1011; 4 cycles in MEM_RD with MemRead=1 IorD=1; MEM_WB MemtoReg=01 RegWrite=1.
- beq (0x04) with Zero=1 -> PCEn=1 PCSource=01 ALUOperation=1000; Zero=0 -> PCEn=0; bne (0x05) -> ALUOperation=1001, same Zero rule.
- Opcode 0x3F, or Opcode 0x00 Funct 0x3F -> FAULT, Fault=1 FaultCause=01, no strobes for 10 cycles; reset low -> State=0, Fault=0.
- WAIT_LIMIT=4, MemReady held low in FETCH -> FAULT after exactly 4 low cycles with cause 10; rerun with MemReady=1 on the 4th cycle -> DECODE.
- jal (0x03) -> PCEn=1 PCSource=10 RegDst=10 MemtoReg=10 RegWrite=1; separately, assert reset mid-cycle in MEM_WR -> MemWrite falls before the next clock edge.
